// File: rtl/tone_scheduler_pkg.sv
// Shared constants, tag type and step helper for the time-multiplexed tone scheduler.
package tone_scheduler_pkg;

  localparam int NCH_DEF           = 4;
  localparam int FPS_DEF           = 16;
  localparam int CIRCLEBITSIZE_DEF = 10;
  localparam int ANGLE_BITS_DEF    = 8;
  localparam int CORDIC_LAT_DEF    = 32;

  localparam int ACC_W = FPS_DEF + CIRCLEBITSIZE_DEF;

  // Sized for the largest supported channel count (16); narrower configs zero-extend.
  localparam int CH_W = 4;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } tag_t;

  // Per-visit step: each channel only advances once every nch clocks.
  function automatic logic [15:0] step_from_freq(input longint unsigned freq_hz,
                                                 input longint unsigned clk_hz,
                                                 input int unsigned     nch);
    longint unsigned full;
    full = (freq_hz << (16 + CIRCLEBITSIZE_DEF)) / clk_hz;
    return 16'(full / longint'(nch));
  endfunction

endpackage

// File: rtl/tone_scheduler_tag_delay_line.sv
// Fixed-depth shift register that carries issue tags alongside the CORDIC pipeline.
module tone_scheduler_tag_delay_line #(
  parameter int DEPTH = 32,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] stage_q, stage_d;

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/tone_scheduler.sv
// Round-robin phase accumulators sharing one pipelined CORDIC; tags each issue
// through the CORDIC latency and emits channel-tagged sine samples.
module tone_scheduler
  import tone_scheduler_pkg::*;
#(
  parameter int NCH           = NCH_DEF,
  parameter int FPS           = FPS_DEF,
  parameter int CIRCLEBITSIZE = CIRCLEBITSIZE_DEF,
  parameter int ANGLE_BITS    = ANGLE_BITS_DEF,
  parameter int CORDIC_LAT    = CORDIC_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(NCH)-1:0]     cfg_ch,
  input  logic [15:0]                cfg_step,
  input  logic                       cfg_en,
  input  logic                       phase_clr,
  output logic [31:0]                cordic_angle,
  input  logic signed [31:0]         cordic_sine,
  output logic                       sample_valid,
  output logic [$clog2(NCH)-1:0]     sample_ch,
  output logic signed [31:0]         sample_data,
  output logic                       frame_start
);

  localparam int CHW = $clog2(NCH);
  localparam int AW  = FPS + CIRCLEBITSIZE;

  logic [CHW-1:0]             slot_q, slot_d;
  logic [NCH-1:0][AW-1:0]     acc_q, acc_d;
  logic [NCH-1:0][15:0]       step_q, step_d;
  logic [NCH-1:0]             en_q, en_d;
  logic [31:0]                angle_q, angle_d;
  tag_t                       issue_tag_q, issue_tag_d;
  tag_t                       cap_tag;
  logic                       sample_valid_q, sample_valid_d;
  logic [CHW-1:0]             sample_ch_q, sample_ch_d;
  logic signed [31:0]         sample_data_q, sample_data_d;
  logic                       frame_q, frame_d;
  logic                       unused_tag_ch;

  always_comb begin
    slot_d        = (slot_q == CHW'(NCH - 1)) ? '0 : slot_q + 1'b1;
    acc_d         = acc_q;
    step_d        = step_q;
    en_d          = en_q;
    angle_d       = angle_q;
    issue_tag_d   = '0;
    frame_d       = (slot_q == '0);

    if (phase_clr) begin
      acc_d = '0;
    end else if (en_q[slot_q]) begin
      angle_d           = 32'(acc_q[slot_q][FPS+ANGLE_BITS-1:FPS]);
      acc_d[slot_q]     = acc_q[slot_q] + AW'(step_q[slot_q]);
      issue_tag_d.valid = 1'b1;
      issue_tag_d.ch    = CH_W'(slot_q);
    end else begin
      acc_d[slot_q] = '0;
    end

    // Issue above used the old step/enable; a fresh enable restarts phase at 0.
    if (cfg_we) begin
      step_d[cfg_ch] = cfg_step;
      en_d[cfg_ch]   = cfg_en;
      if (cfg_en && !en_q[cfg_ch]) begin
        acc_d[cfg_ch] = '0;
      end
    end

    sample_valid_d = cap_tag.valid;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    if (cap_tag.valid) begin
      sample_ch_d   = cap_tag.ch[CHW-1:0];
      sample_data_d = cordic_sine;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q         <= '0;
      acc_q          <= '0;
      step_q         <= '0;
      en_q           <= '0;
      angle_q        <= '0;
      issue_tag_q    <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      frame_q        <= 1'b0;
    end else begin
      slot_q         <= slot_d;
      acc_q          <= acc_d;
      step_q         <= step_d;
      en_q           <= en_d;
      angle_q        <= angle_d;
      issue_tag_q    <= issue_tag_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
      frame_q        <= frame_d;
    end
  end

  // Issue tag is registered with the angle, so the line only spans the CORDIC latency.
  tone_scheduler_tag_delay_line #(
    .DEPTH (CORDIC_LAT),
    .W     ($bits(tag_t))
  ) u_tag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (issue_tag_q),
    .dout  (cap_tag)
  );

  assign unused_tag_ch = ^cap_tag.ch;

  assign cordic_angle = angle_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign frame_start  = frame_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler with an angle-echo CORDIC stub (latency 4, 4 channels).
module tb_tone_scheduler;

  localparam int NCH = 4;
  localparam int L   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [15:0]       cfg_step = '0;
  logic              cfg_en = 1'b0;
  logic              phase_clr = 1'b0;
  logic [31:0]       cordic_angle;
  logic signed [31:0] cordic_sine;
  logic              sample_valid;
  logic [1:0]        sample_ch;
  logic signed [31:0] sample_data;
  logic              frame_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_scheduler #(
    .NCH(NCH), .FPS(16), .CIRCLEBITSIZE(10), .ANGLE_BITS(8), .CORDIC_LAT(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_step(cfg_step),
    .cfg_en(cfg_en), .phase_clr(phase_clr), .cordic_angle(cordic_angle),
    .cordic_sine(cordic_sine), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .frame_start(frame_start)
  );

  // CORDIC stub: sine is the angle delayed by L clocks.
  logic [31:0] stub_q [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) stub_q[i] <= stub_q[i-1];
    stub_q[0] <= cordic_angle;
  end
  assign cordic_sine = signed'(stub_q[L-1]);

  // Reference model: per-channel phase, list of pending issues with their due edge.
  typedef struct { int due; int ch; int ang; } pend_t;
  pend_t           pq[$];
  int unsigned     macc [NCH];
  int unsigned     mstep[NCH];
  bit              men  [NCH];
  int              m_slot, e_cnt;
  logic            m_valid, m_frame;
  logic [1:0]      m_ch;
  logic [31:0]     m_data, m_angle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete();
      for (int i = 0; i < NCH; i++) begin macc[i] = 0; mstep[i] = 0; men[i] = 0; end
      m_slot = 0; e_cnt = 0;
      m_valid = 0; m_frame = 0; m_ch = '0; m_data = '0; m_angle = '0;
    end else begin
      int s;
      e_cnt++;
      m_valid = 0;
      if (pq.size() > 0 && pq[0].due == e_cnt) begin
        m_valid = 1; m_ch = 2'(pq[0].ch); m_data = 32'(pq[0].ang);
        void'(pq.pop_front());
      end
      s = m_slot;
      m_frame = (s == 0);
      if (phase_clr) begin
        for (int i = 0; i < NCH; i++) macc[i] = 0;
      end else if (men[s]) begin
        m_angle = 32'((macc[s] >> 16) & 255);
        pq.push_back('{due: e_cnt + L + 1, ch: s, ang: int'(m_angle)});
        macc[s] = (macc[s] + mstep[s]) % (1 << 26);
      end else begin
        macc[s] = 0;
      end
      if (cfg_we) begin
        if (cfg_en && !men[cfg_ch]) macc[cfg_ch] = 0;
        mstep[cfg_ch] = cfg_step;
        men[cfg_ch]   = cfg_en;
      end
      m_slot = (s + 1) % NCH;
    end
  end

  logic [67:0] obs_w, exp_w;
  assign obs_w = {sample_valid, sample_ch, sample_data, cordic_angle, frame_start};
  assign exp_w = {m_valid, m_ch, m_data, m_angle, m_frame};

  function automatic int ramp_val(input int k, input int step);
    longint p;
    p = (longint'(k) * longint'(step)) % (longint'(1) << 26);
    return int'((p >> 16) & 255);
  endfunction

  task automatic cfg_write(input int ch, input int step, input bit en);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_step = 16'(step); cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    int frames = 0, vcount = 0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs_w !== 68'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", obs_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL idle_model got %h want %h", obs_w, exp_w); end
      checks++;
      if (cordic_angle !== 32'd0) begin errors++; $display("FAIL idle_angle got %0d want 0", cordic_angle); end
      if (sample_valid) vcount++;
      if (frame_start) frames++;
    end
    checks++;
    if (vcount != 0) begin errors++; $display("FAIL idle_valid_count got %0d want 0", vcount); end
    checks++;
    if (frames != 25) begin errors++; $display("FAIL idle_frame_count got %0d want 25", frames); end
  endtask

  task automatic test_ch0_ramp_wrap;
    int guard = 0, k = 0, fi = -1, vi = -1, last = -1, want;
    while (!frame_start && guard < 8) begin @(negedge clk); guard++; end
    checks++;
    if (!frame_start) begin errors++; $display("FAIL align_frame got 0 want 1"); end
    cfg_write(0, 'h8000, 1'b1);
    for (int n = 1; n <= 2060 * 4 + 20; n++) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL ramp_model n=%0d got %h want %h", n, obs_w, exp_w); end
      if (frame_start && fi < 0) fi = n;
      if (sample_valid) begin
        if (vi < 0) vi = n;
        want = ramp_val(k, 'h8000);
        checks++;
        if (sample_ch !== 2'd0 || sample_data !== want) begin
          errors++; $display("FAIL ramp_value k=%0d got ch%0d/%0d want ch0/%0d", k, sample_ch, sample_data, want);
        end
        if (last >= 0) begin
          checks++;
          if (n - last != 4) begin errors++; $display("FAIL ramp_spacing got %0d want 4", n - last); end
        end
        last = n; k++;
      end
    end
    checks++;
    if (vi - fi != 5) begin errors++; $display("FAIL first_strobe_latency got %0d want 5", vi - fi); end
    checks++;
    if (k < 2050) begin errors++; $display("FAIL ramp_count got %0d want >=2050", k); end
    cfg_write(0, 0, 1'b0);
  endtask

  task automatic test_interleave;
    int k1 = 0, k2 = 0, last_n = -1, last_ch = -1, strobes = 0, want;
    cfg_write(1, 'hFFFF, 1'b1);
    cfg_write(2, 'h4000, 1'b1);
    for (int n = 0; n < 72; n++) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL ilv_model n=%0d got %h want %h", n, obs_w, exp_w); end
      if (sample_valid && n >= 12) begin
        want = (sample_ch == 2'd1) ? ramp_val(k1, 'hFFFF) : ramp_val(k2, 'h4000);
        checks++;
        if ((sample_ch != 2'd1 && sample_ch != 2'd2) || sample_data !== want) begin
          errors++; $display("FAIL ilv_value got ch%0d/%0d want %0d", sample_ch, sample_data, want);
        end
        if (last_n >= 0) begin
          checks++;
          if (sample_ch == 2'd2 && !(last_ch == 1 && n - last_n == 1)) begin
            errors++; $display("FAIL ilv_gap_ch2 got %0d want 1", n - last_n);
          end else if (sample_ch == 2'd1 && !(last_ch == 2 && n - last_n == 3)) begin
            errors++; $display("FAIL ilv_gap_ch1 got %0d want 3", n - last_n);
          end
        end
        last_n = n; last_ch = int'(sample_ch); strobes++;
      end
      if (sample_valid) begin
        if (sample_ch == 2'd1) k1++;
        else if (sample_ch == 2'd2) k2++;
      end
    end
    checks++;
    if (strobes != 30) begin errors++; $display("FAIL ilv_strobe_count got %0d want 30", strobes); end
    cfg_write(1, 0, 1'b0);
    cfg_write(2, 0, 1'b0);
  endtask

  task automatic test_phase_clr;
    int vcnt = 0;
    for (int c = 0; c < NCH; c++) cfg_write(c, int'($urandom_range(16'h1000, 16'hFFFF)), 1'b1);
    repeat (24) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL clr_pre_model got %h want %h", obs_w, exp_w); end
    end
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL clr_model i=%0d got %h want %h", i, obs_w, exp_w); end
      if (i <= 4) begin
        checks++;
        if (cordic_angle !== 32'd0) begin errors++; $display("FAIL clr_angle i=%0d got %0d want 0", i, cordic_angle); end
      end
      if (i >= 2 && i <= 5 && sample_valid) vcnt++;
    end
    checks++;
    if (vcnt != 3) begin errors++; $display("FAIL clr_missing_strobe got %0d want 3", vcnt); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_inflight;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_w !== 68'h0) begin errors++; $display("FAIL rst_inflight_outputs got %h want 0", obs_w); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_w !== 68'h0) begin errors++; $display("FAIL rst_hold_outputs got %h want 0", obs_w); end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (sample_valid !== 1'b0 || obs_w !== exp_w) begin
        errors++; $display("FAIL rst_release got %h want %h", obs_w, exp_w);
      end
    end
  endtask

  task automatic test_random;
    repeat (800) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL rand_model got %h want %h", obs_w, exp_w); end
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_step  = 16'($urandom);
      cfg_en    = ($urandom_range(0, 2) != 0);
      phase_clr = ($urandom_range(0, 24) == 0);
    end
    cfg_we = 1'b0; phase_clr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (obs_w !== exp_w) begin errors++; $display("FAIL rand_drain got %h want %h", obs_w, exp_w); end
    end
  endtask

  initial begin
    test_reset();
    test_ch0_ramp_wrap();
    test_interleave();
    test_phase_clr();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
- Time-multiplexes one shared pipelined CORDIC sine/cosine core across NCH independent tone channels.
- Holds a phase accumulator and step size per channel; issues one angle per clock in round-robin slot order.
- Tracks each issued angle through the CORDIC latency and delivers tagged sine samples on a valid-strobed output.
- Sits between the configuration/register interface and the CORDIC instance, replacing one accumulator-plus-CORDIC pair per tone.

Parameters:
- NCH, 4, number of tone channels (power of two, 2..16)
- FPS, 16, fractional bits of the phase accumulator
- CIRCLEBITSIZE, 10, integer phase bits; accumulator width is FPS+CIRCLEBITSIZE
- ANGLE_BITS, 8, accumulator bits [FPS+ANGLE_BITS-1:FPS] sent to the CORDIC as the angle
- CORDIC_LAT, 32, cycles from a cordic_angle change to the matching valid cordic_sine

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  log2(NCH)  channel addressed by the write
- cfg_step  in  16  phase step size per channel visit
- cfg_en  in  1  channel enable
- phase_clr  in  1  synchronous clear of all accumulators
- cordic_angle  out  32  registered angle to the CORDIC, zero-extended from ANGLE_BITS
- cordic_sine  in  32 signed  CORDIC sine result
- sample_valid  out  1  one-cycle strobe for a captured sample
- sample_ch  out  log2(NCH)  channel of the current sample
- sample_data  out  32 signed  captured sine value
- frame_start  out  1  high during the cycle that slot 0 is issued

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - all accumulators, steps and enables, the slot counter and the tag pipeline
  - cordic_angle, sample_valid, sample_ch, sample_data and frame_start, all to 0
- Reset asserted mid-operation discards every in-flight tag; no sample_valid appears after reset release until new issues complete.
- Slot counter:
  - increments by 1 every clk and wraps NCH-1 -> 0
  - each channel is therefore visited once per NCH cycles
- Slot s, channel s enabled, at edge t:
  - cordic_angle <= {0, acc[s][FPS+ANGLE_BITS-1:FPS]}, using the pre-increment value
  - acc[s] <= acc[s] + cfg_step value stored for s, modulo 2^(FPS+CIRCLEBITSIZE)
  - {valid=1, ch=s} pushed into the tag pipeline
- Slot s, channel s disabled:
  - acc[s] forced to 0
  - cordic_angle holds its previous value
  - tag pushed with valid=0
- Tag pipeline is a CORDIC_LAT-deep shift register. A tag issued at edge t is captured at edge t+CORDIC_LAT+1:
  - sample_data <= cordic_sine
  - sample_ch <= tag ch
  - sample_valid <= 1 for one cycle
- Invalid tags produce sample_valid=0; sample_data and sample_ch hold.
- Throughput: one sample per enabled channel per NCH cycles. There is no backpressure; the consumer must accept every strobe.
- Configuration write:
  - updates step[cfg_ch] and en[cfg_ch] at the edge
  - a write to the channel being issued in that same cycle does not affect that issue; it takes effect from the next visit
- Enable transition 0->1: the phase starts from 0 on the first visit, so the first angle is 0.
- phase_clr (has priority over accumulation):
  - all accumulators <= 0 at that edge
  - the current slot's tag is pushed invalid and cordic_angle holds
  - the slot counter is unaffected
- Simultaneous cfg_we and phase_clr: both take effect; the accumulator is cleared and the new step is stored.
- frame_start is a registered flag, high during the cycle in which cordic_angle presents the slot-0 issue.

Decomposition:
- Shared package holds:
  - the accumulator-width constant ACC_W = FPS+CIRCLEBITSIZE
  - the channel index width localparam
  - the tag struct {valid, ch}
  - the step-from-frequency constant function (freq * 2^16 * 2^CIRCLEBITSIZE / clock rate, divided by NCH for the per-visit step)
- One natural sub-module: tag_delay_line, a parameterised depth/width shift register carrying tags alongside the CORDIC.

Test Plan:
- Bench uses a CORDIC stub that echoes the angle as sine with CORDIC_LAT=4, NCH=4.
- Reset release with no configuration -> sample_valid stays 0 for 100 cycles; cordic_angle=0; frame_start pulses every 4 cycles.
- ch0 en=1, step=0x8000 -> sample_ch=0 every 4 cycles; sample_data sequence 0,0,1,1,2,2,... The first sample strobe comes 5 cycles after the first ch0 issue.
- ch0 step=0x8000 runs to wrap -> after 2048 visits the angle returns 0 (8-bit angle wraps at 255 -> 0 every 512 visits); no glitch in the sequence.
- ch1 step=0x10000-1 and ch2 step=0x4000 simultaneously -> interleaved strobes with ch=1 and ch=2 exactly 1 cycle apart, then a 3-cycle gap. Values match the independent accumulator model.
- phase_clr pulsed while ch0..3 run -> that cycle's tag is invalid (one strobe is missing after 5 cycles); next visits issue angle 0 on all channels.
- rst_n low while 4 tags are in flight -> no sample_valid at any point after release until new issues; all outputs read 0 during reset.
